// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - framebuffer RAM access bus between arbiter and single-port RAM
interface vram_arbiter_if;
  logic        ram_en;
  logic        ram_we;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  modport master (
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport slave (
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM scheduler: display fetch > fill engine > write port
module vram_arbiter #(
  parameter int COLS  = 160,
  parameter int ROWS  = 120,
  parameter int HACT  = 640,
  parameter int VACT  = 480,
  parameter int CELLS = COLS * ROWS
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        pix_en,
  input  logic [9:0]  h,
  input  logic [9:0]  v,
  input  logic        wr_req,
  input  logic [14:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ack,
  output logic        wr_err,
  input  logic        fill_req,
  input  logic [7:0]  fill_color,
  output logic        fill_busy,
  vram_arbiter_if.master ram,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue
);

  localparam logic [0:0]  IDLE = 1'b0;
  localparam logic [0:0]  FILL = 1'b1;
  localparam logic [9:0]  HACT_W  = 10'(HACT);
  localparam logic [9:0]  VACT_W  = 10'(VACT);
  localparam logic [14:0] CELLS_W = 15'(CELLS);
  localparam logic [14:0] LAST_W  = 15'(CELLS - 1);

  logic [0:0]  state;
  logic [14:0] fill_cnt;
  logic [7:0]  fill_val;
  logic [7:0]  rgb;
  logic        d1_fetch, d1_blank, d2_fetch, d2_blank;
  logic        active, fetch_need, blank_need, wr_oor;
  logic [7:0]  row, col;
  logic [14:0] fetch_addr;

  always_comb begin
    active     = (h < HACT_W) && (v < VACT_W);
    fetch_need = pix_en && active && (h[1:0] == 2'b00);
    blank_need = pix_en && !active;
    row        = v[9:2];
    col        = h[9:2];
    // row*160 = row*128 + row*32
    fetch_addr = 15'({row, 7'b0}) + 15'({row, 5'b0}) + 15'(col);
    wr_oor     = (wr_addr >= CELLS_W);
  end

  assign fill_busy = (state == FILL);
  assign red       = rgb[7:5];
  assign green     = rgb[4:2];
  assign blue      = rgb[1:0];

  always_ff @(posedge clk) begin
    if (clr) begin
      ram.ram_en    <= 1'b0;
      ram.ram_we    <= 1'b0;
      ram.ram_addr  <= '0;
      ram.ram_wdata <= '0;
      wr_ack        <= 1'b0;
      wr_err        <= 1'b0;
      state         <= IDLE;
      fill_cnt      <= '0;
      fill_val      <= '0;
      rgb           <= '0;
      d1_fetch      <= 1'b0;
      d1_blank      <= 1'b0;
      d2_fetch      <= 1'b0;
      d2_blank      <= 1'b0;
    end else begin
      ram.ram_en <= 1'b0;
      ram.ram_we <= 1'b0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;

      d1_fetch <= fetch_need;
      d1_blank <= blank_need;
      d2_fetch <= d1_fetch;
      d2_blank <= d1_blank;
      if (d2_fetch) begin
        rgb <= ram.ram_rdata;
      end else if (d2_blank) begin
        rgb <= '0;
      end

      if (fetch_need) begin
        ram.ram_en   <= 1'b1;
        ram.ram_addr <= fetch_addr;
      end else if (state == FILL) begin
        ram.ram_en    <= 1'b1;
        ram.ram_we    <= 1'b1;
        ram.ram_addr  <= fill_cnt;
        ram.ram_wdata <= fill_val;
        if (fill_cnt == LAST_W) begin
          state    <= IDLE;
          fill_cnt <= '0;
        end else begin
          fill_cnt <= fill_cnt + 15'd1;
        end
      end else if (wr_req && !wr_ack) begin
        // the cycle right after an ack still shows the old request, so skip it
        wr_ack <= 1'b1;
        if (wr_oor) begin
          wr_err <= 1'b1;
        end else begin
          ram.ram_en    <= 1'b1;
          ram.ram_we    <= 1'b1;
          ram.ram_addr  <= wr_addr;
          ram.ram_wdata <= wr_data;
        end
      end

      if (state == IDLE && fill_req) begin
        state    <= FILL;
        fill_cnt <= '0;
        fill_val <= fill_color;
      end
    end
  end

endmodule
